axi_dma_wr: RTL

AXI4 write-master DMA that streams 32-bit words from the accelerator's output path (OFM writer) back to external DRAM. It is the write-side counterpart of axi_dma_rd and uses the same functional handshake (start_dma, num_trans, start_addr, done_o). Transfers are split into INCR bursts that never cross a 4 KB boundary. One burst is outstanding at a time.

---
 rtl/axi_dma_wr_pkg.sv | 18 +
 rtl/axi_dma_wr_if.sv | 42 ++++
 rtl/axi_dma_wr.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axi_dma_wr_pkg.sv
// Shared AXI constants and DMA state encodings.
// Imported by axi_dma_wr and axi_dma_rd.
package axi_dma_wr_pkg;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/axi_dma_wr_if.sv
// AXI4 write channels (AW, W, B) of the DMA write master.
// master: DMA side, slave: memory side.
interface axi_dma_wr_if #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8
);

  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [AXI_WIDTH_AD-1:0] M_AWADDR;
  logic [7:0]              M_AWLEN;
  logic [2:0]              M_AWSIZE;
  logic [1:0]              M_AWBURST;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [AXI_WIDTH_DA-1:0] M_WDATA;
  logic [AXI_WIDTH_DS-1:0] M_WSTRB;
  logic                    M_WLAST;
  logic                    M_BVALID;
  logic                    M_BREADY;
  logic [1:0]              M_BRESP;

  modport master (
    output M_AWVALID, M_AWADDR, M_AWLEN,
    output M_AWSIZE, M_AWBURST,
    output M_WVALID, M_WDATA, M_WSTRB,
    output M_WLAST, M_BREADY,
    input  M_AWREADY, M_WREADY,
    input  M_BVALID, M_BRESP
  );

  modport slave (
    input  M_AWVALID, M_AWADDR, M_AWLEN,
    input  M_AWSIZE, M_AWBURST,
    input  M_WVALID, M_WDATA, M_WSTRB,
    input  M_WLAST, M_BREADY,
    output M_AWREADY, M_WREADY,
    output M_BVALID, M_BRESP
  );

endinterface

// File: rtl/axi_dma_wr.sv
// AXI4 write DMA: streams producer words to DRAM in INCR bursts
// that never cross 4 KB; one burst outstanding, AW then W then B.
// Ports: clk/rstn, start_dma/num_trans/start_addr command,
// data_i/data_vld_i/data_rdy_o producer stream, data_cnt_o,
// done_o pulse, sticky err_o, m_axi AXI write channels.
module axi_dma_wr
  import axi_dma_wr_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
  parameter int BITS_TRANS   = 18,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_dma,
  input  logic [BITS_TRANS-1:0]   num_trans,
  input  logic [AXI_WIDTH_AD-1:0] start_addr,
  input  logic [AXI_WIDTH_DA-1:0] data_i,
  input  logic                    data_vld_i,
  output logic                    data_rdy_o,
  output logic [BITS_TRANS-1:0]   data_cnt_o,
  output logic                    done_o,
  output logic                    err_o,
  axi_dma_wr_if.master            m_axi
);

  dma_state_e state, nxt;

  logic [AXI_WIDTH_AD-1:0] addr;
  logic [BITS_TRANS-1:0]   rem;
  logic [18:0]             len;
  logic [8:0]              beat;
  logic [BITS_TRANS-1:0]   cnt;
  logic                    err;

  logic                    start_ok;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    last_beat;
  logic [BITS_TRANS-1:0]   rem_nxt;
  logic [AXI_WIDTH_AD-1:0] addr_nxt;

  // Beats in the next burst: limited by words left, MAX_BURST
  // and the words remaining up to the next 4 KB page.
  function automatic logic [18:0] burst_len(
    input logic [BITS_TRANS-1:0] r,
    input logic [11:0]           a
  );
    logic [18:0] l;
    logic [18:0] b;
    b = 19'((13'(BOUNDARY_4K) - {1'b0, a}) >> 2);
    l = 19'(r);
    if (l > 19'(MAX_BURST)) l = 19'(MAX_BURST);
    if (l > b) l = b;
    return l;
  endfunction

  assign start_ok  = (state == ST_IDLE) && start_dma;
  assign aw_hs     = (state == ST_AW) && m_axi.M_AWREADY;
  assign w_hs      = (state == ST_W) && data_vld_i
                   && m_axi.M_WREADY;
  assign b_hs      = (state == ST_B) && m_axi.M_BVALID;
  assign last_beat = (19'(beat) == len - 19'd1);
  assign rem_nxt   = rem - BITS_TRANS'(len);
  assign addr_nxt  = addr + (AXI_WIDTH_AD'(len) << 2);

  assign data_cnt_o = cnt;
  assign err_o      = err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_dma)
          nxt = (num_trans == '0) ? ST_DONE : ST_AW;
      end
      ST_AW: begin
        if (m_axi.M_AWREADY) nxt = ST_W;
      end
      ST_W: begin
        if (w_hs && last_beat) nxt = ST_B;
      end
      ST_B: begin
        if (m_axi.M_BVALID)
          nxt = (rem_nxt == '0) ? ST_DONE : ST_AW;
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi.M_AWVALID = 1'b0;
    m_axi.M_AWADDR  = '0;
    m_axi.M_AWLEN   = '0;
    m_axi.M_AWSIZE  = SIZE_4B;
    m_axi.M_AWBURST = BURST_INCR;
    m_axi.M_WVALID  = 1'b0;
    m_axi.M_WDATA   = '0;
    m_axi.M_WSTRB   = '1;
    m_axi.M_WLAST   = 1'b0;
    m_axi.M_BREADY  = 1'b0;
    data_rdy_o      = 1'b0;
    done_o          = 1'b0;
    unique case (state)
      ST_AW: begin
        m_axi.M_AWVALID = 1'b1;
        m_axi.M_AWADDR  = addr;
        m_axi.M_AWLEN   = 8'(len - 19'd1);
      end
      ST_W: begin
        m_axi.M_WVALID = data_vld_i;
        m_axi.M_WDATA  = data_i;
        m_axi.M_WLAST  = last_beat;
        data_rdy_o     = m_axi.M_WREADY;
      end
      ST_B:    m_axi.M_BREADY = 1'b1;
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr <= '0;
      rem  <= '0;
      len  <= '0;
      beat <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      unique case (1'b1)
        start_ok: begin
          addr <= start_addr;
          rem  <= num_trans;
          cnt  <= '0;
          err  <= 1'b0;
          len  <= burst_len(num_trans, start_addr[11:0]);
        end
        aw_hs: beat <= '0;
        w_hs: begin
          beat <= beat + 9'd1;
          cnt  <= cnt + BITS_TRANS'(1);
        end
        b_hs: begin
          err  <= err | (m_axi.M_BRESP != RESP_OKAY);
          rem  <= rem_nxt;
          addr <= addr_nxt;
          len  <= burst_len(rem_nxt, addr_nxt[11:0]);
        end
        default: ;
      endcase
    end
  end

endmodule
